// File: rtl/sudoku_pkg.sv
// rtl/sudoku_pkg.sv - shared constants, error codes and FSM encoding for the sudoku grid checker
package sudoku_pkg;

   localparam int GRID_DIM = 9;
   localparam int N_CELLS  = 81;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_RANGE = 2'd1,
      ERR_DUP   = 2'd2
   } err_code_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DRAIN,
      ST_REPORT
   } chk_state_t;

   // One-hot mask bit for digit d (1..9); only meaningful for in-range digits.
   function automatic logic [GRID_DIM-1:0] digit_bit(input logic [3:0] d);
      return GRID_DIM'(1) << (d - 4'd1);
   endfunction

endpackage

// File: rtl/sudoku_pos_tracker.sv
// rtl/sudoku_pos_tracker.sv - cell index/row/column/box counters for the check stage
module sudoku_pos_tracker
   import sudoku_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       advance,
   output logic [6:0] idx,
   output logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] box
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         idx <= '0;
         row <= '0;
         col <= '0;
         box <= '0;
      end else if (advance) begin
         idx <= (idx == 7'(N_CELLS - 1)) ? '0 : idx + 7'd1;
         if (col == 4'(GRID_DIM - 1)) begin
            col <= '0;
            if (row == 4'(GRID_DIM - 1)) begin
               row <= '0;
               box <= '0;
            end else begin
               row <= row + 4'd1;
               // Leaving the last row of a band moves to the next band; otherwise back to its first box.
               box <= (row == 4'd2 || row == 4'd5) ? box + 4'd1 : box - 4'd2;
            end
         end else begin
            col <= col + 4'd1;
            if (col == 4'd2 || col == 4'd5)
               box <= box + 4'd1;
         end
      end
   end

endmodule

// File: rtl/sudoku_checker.sv
// rtl/sudoku_checker.sv - reads back the 81-cell grid and validates it; SUDOKU_CHK_EARLY_EXIT_EN stops at the first error
module sudoku_checker
   import sudoku_pkg::*;
#(
   parameter int ADDR_W    = 7,
   parameter int DATA_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              RAM_ceb,
   output logic              RAM_web,
   output logic [ADDR_W-1:0] RAM_A,
   input  logic [DATA_W-1:0] RAM_Q,
   output logic              busy,
   output logic              chk_done,
   output logic              pass,
   output logic [6:0]        err_addr,
   output logic [1:0]        err_code
);

`ifdef SUDOKU_CHK_EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif

   chk_state_t          state;
   err_code_t           err_q;
   logic [6:0]          issue;
   logic                chk_valid;
   logic [GRID_DIM-1:0] row_mask [GRID_DIM];
   logic [GRID_DIM-1:0] col_mask [GRID_DIM];
   logic [GRID_DIM-1:0] box_mask [GRID_DIM];
   logic [6:0]          cur_idx;
   logic [3:0]          cur_row, cur_col, cur_box;
   logic                in_range, is_dup, cell_err, first_err, can_start;
   logic [GRID_DIM-1:0] cell_bit;

   sudoku_pos_tracker u_pos (
      .clk     (clk),
      .rst     (rst),
      .clear   (can_start),
      .advance (chk_valid),
      .idx     (cur_idx),
      .row     (cur_row),
      .col     (cur_col),
      .box     (cur_box)
   );

   always_comb begin
      in_range  = (RAM_Q != '0) && (RAM_Q <= DATA_W'(GRID_DIM));
      cell_bit  = in_range ? digit_bit(RAM_Q[3:0]) : '0;
      is_dup    = |((row_mask[cur_row] | col_mask[cur_col] | box_mask[cur_box]) & cell_bit);
      cell_err  = chk_valid && (!in_range || is_dup);
      first_err = cell_err && (err_q == ERR_NONE);
      can_start = start && (state == ST_IDLE || state == ST_REPORT);
   end

   assign RAM_web  = 1'b1;
   assign busy     = (state == ST_SCAN) || (state == ST_DRAIN);
   assign err_code = err_q;

   always_ff @(posedge clk) begin
      if (rst || can_start) begin
         for (int i = 0; i < GRID_DIM; i++) begin
            row_mask[i] <= '0;
            col_mask[i] <= '0;
            box_mask[i] <= '0;
         end
         state     <= rst ? ST_IDLE : ST_SCAN;
         RAM_ceb   <= !rst;
         RAM_A     <= rst ? '0 : ADDR_W'(BASE_ADDR);
         issue     <= '0;
         chk_valid <= 1'b0;
         chk_done  <= 1'b0;
         pass      <= 1'b0;
         err_addr  <= '0;
         err_q     <= ERR_NONE;
      end else begin
         if (chk_valid && in_range && !is_dup) begin
            row_mask[cur_row] <= row_mask[cur_row] | cell_bit;
            col_mask[cur_col] <= col_mask[cur_col] | cell_bit;
            box_mask[cur_box] <= box_mask[cur_box] | cell_bit;
         end
         if (first_err) begin
            err_addr <= cur_idx;
            err_q    <= in_range ? ERR_DUP : ERR_RANGE;
         end
         case (state)
            ST_SCAN: begin
               chk_valid <= 1'b1;
               if (EARLY_EXIT && first_err) begin
                  // Drop the read still in flight; the grid is already known bad.
                  state     <= ST_REPORT;
                  RAM_ceb   <= 1'b0;
                  chk_valid <= 1'b0;
                  chk_done  <= 1'b1;
                  pass      <= 1'b0;
               end else if (issue == 7'(N_CELLS - 1)) begin
                  state   <= ST_DRAIN;
                  RAM_ceb <= 1'b0;
               end else begin
                  issue <= issue + 7'd1;
                  RAM_A <= RAM_A + ADDR_W'(1);
               end
            end
            ST_DRAIN: begin
               chk_valid <= 1'b0;
               state     <= ST_REPORT;
               chk_done  <= 1'b1;
               pass      <= (err_q == ERR_NONE) && !cell_err;
            end
            default: chk_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_sudoku_checker.sv
// tb/tb_sudoku_checker.sv - randomized self-checking bench for sudoku_checker against a rule-level grid model
module tb_sudoku_checker;

   logic       clk = 1'b0;
   logic       rst, start;
   logic       RAM_ceb, RAM_web;
   logic [6:0] RAM_A;
   logic [7:0] RAM_Q;
   logic       busy, chk_done, pass;
   logic [6:0] err_addr;
   logic [1:0] err_code;

   logic [7:0] mem [0:127];
   int         grid [81];
   int         checks = 0;
   int         errors = 0;
   int         ceb_cnt, addr_bad;
   logic [6:0] exp_addr;

   sudoku_checker dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .RAM_ceb  (RAM_ceb),
      .RAM_web  (RAM_web),
      .RAM_A    (RAM_A),
      .RAM_Q    (RAM_Q),
      .busy     (busy),
      .chk_done (chk_done),
      .pass     (pass),
      .err_addr (err_addr),
      .err_code (err_code)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM plus a log of every issued read address.
   always @(posedge clk) begin
      if (RAM_ceb) begin
         RAM_Q <= mem[RAM_A];
         if (RAM_A !== exp_addr) addr_bad++;
         exp_addr++;
         ceb_cnt++;
      end
   end

   task automatic make_valid();
      int p [9];
      int t, j, b, r1, r2;
      for (int i = 0; i < 9; i++) p[i] = i + 1;
      for (int i = 8; i > 0; i--) begin
         j = $urandom_range(0, i);
         t = p[i]; p[i] = p[j]; p[j] = t;
      end
      for (int r = 0; r < 9; r++)
         for (int c = 0; c < 9; c++)
            grid[r*9+c] = p[(r*3 + r/3 + c) % 9];
      b  = $urandom_range(0, 2);
      r1 = b*3 + $urandom_range(0, 2);
      r2 = b*3 + $urandom_range(0, 2);
      for (int c = 0; c < 9; c++) begin
         t = grid[r1*9+c]; grid[r1*9+c] = grid[r2*9+c]; grid[r2*9+c] = t;
      end
   endtask

   function automatic void model(output int ea, output int ec);
      int v;
      ea = 0;
      ec = 0;
      for (int k = 0; k < 81; k++) begin
         v = grid[k];
         if (v < 1 || v > 9) begin ea = k; ec = 1; return; end
         for (int j = 0; j < k; j++) begin
            if (grid[j] == v && (j/9 == k/9 || j%9 == k%9 ||
                (j/27 == k/27 && (j%9)/3 == (k%9)/3))) begin
               ea = k; ec = 2; return;
            end
         end
      end
   endfunction

   task automatic run_check(input string name, input bit pulse);
      int ea, ec, exp_lat, exp_reads, cyc, busy_bad;
      bit done;
      for (int i = 0; i < 81; i++) mem[i] = 8'(grid[i]);
      model(ea, ec);
      exp_lat   = 82;
      exp_reads = 81;
`ifdef SUDOKU_CHK_EARLY_EXIT_EN
      if (ec != 0) begin
         exp_lat   = ea + 2;
         exp_reads = (ea + 2 > 81) ? 81 : ea + 2;
      end
`endif
      ceb_cnt  = 0;
      addr_bad = 0;
      exp_addr = '0;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      checks++;
      if (chk_done !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL %s start_ack: chk_done=%b busy=%b, required chk_done=0 busy=1", name, chk_done, busy);
      end
      done = 0; cyc = 0; busy_bad = 0;
      while (!done && cyc < 200) begin
         @(posedge clk);
         cyc++;
         #1;
         if (chk_done === 1'b1) done = 1;
         else begin
            if (busy !== 1'b1) busy_bad++;
            start = pulse && (cyc == 1 || cyc == 40);
         end
      end
      start = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s timeout: chk_done never rose within 200 cycles", name);
         return;
      end
      checks++;
      if (cyc != exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d cycles, required %0d", name, cyc, exp_lat);
      end
      checks++;
      if (busy_bad != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy: %0d low cycles during scan, final busy=%b, required 0/0", name, busy_bad, busy);
      end
      checks++;
      if (pass !== (ec == 0)) begin
         errors++;
         $display("FAIL %s pass: got %b, required %b", name, pass, (ec == 0));
      end
      checks++;
      if (err_code !== 2'(ec)) begin
         errors++;
         $display("FAIL %s err_code: got %0d, required %0d", name, err_code, ec);
      end
      checks++;
      if (err_addr !== 7'(ea)) begin
         errors++;
         $display("FAIL %s err_addr: got %0d, required %0d", name, err_addr, ea);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ceb_cnt != exp_reads || addr_bad != 0 || chk_done !== 1'b1) begin
         errors++;
         $display("FAIL %s reads: count=%0d bad_addr=%0d chk_done=%b, required %0d/0/1",
                  name, ceb_cnt, addr_bad, chk_done, exp_reads);
      end
   endtask

   task automatic test_reset();
      checks++;
      if (RAM_ceb !== 1'b0 || RAM_A !== 7'd0 || RAM_web !== 1'b1 || busy !== 1'b0 ||
          chk_done !== 1'b0 || pass !== 1'b0 || err_addr !== 7'd0 || err_code !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: ceb=%b A=%0d web=%b busy=%b done=%b pass=%b addr=%0d code=%0d, required 0 0 1 0 0 0 0 0",
                  RAM_ceb, RAM_A, RAM_web, busy, chk_done, pass, err_addr, err_code);
      end
   endtask

   task automatic test_valid();
      for (int i = 0; i < 3; i++) begin
         make_valid();
         run_check("valid", 0);
      end
   endtask

   task automatic test_row_dup();
      make_valid();
      grid[10] = grid[9];
      run_check("row_dup", 0);
   endtask

   task automatic test_range();
      make_valid();
      grid[40] = 0;
      grid[60] = 12;
      run_check("range_zero", 0);
      make_valid();
      grid[3] = 8'h11;
      run_check("range_upper_bits", 0);
   endtask

   task automatic test_box_dup();
      make_valid();
      grid[10] = grid[0];
      run_check("box_dup", 0);
   endtask

   task automatic test_early_dup5();
      make_valid();
      grid[5] = grid[4];
      run_check("dup_cell5", 0);
   endtask

   task automatic test_reset_mid_scan();
      make_valid();
      for (int i = 0; i < 81; i++) mem[i] = 8'(grid[i]);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (30) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (RAM_ceb !== 1'b0 || busy !== 1'b0 || chk_done !== 1'b0 || err_code !== 2'd0 || RAM_A !== 7'd0) begin
         errors++;
         $display("FAIL mid_reset: ceb=%b busy=%b done=%b code=%0d A=%0d, required 0 0 0 0 0",
                  RAM_ceb, busy, chk_done, err_code, RAM_A);
      end
      @(negedge clk) rst = 1'b0;
      make_valid();
      grid[$urandom_range(20, 70)] = $urandom_range(0, 255);
      run_check("after_reset", 1);
   endtask

   task automatic test_random();
      int a, b;
      for (int it = 0; it < 8; it++) begin
         make_valid();
         case ($urandom_range(0, 2))
            0: grid[$urandom_range(0, 80)] = $urandom_range(0, 255);
            1: begin
               a = $urandom_range(0, 80);
               b = $urandom_range(0, 80);
               grid[b] = grid[a];
            end
            default: ;
         endcase
         run_check("random", it[0]);
      end
   endtask

   task automatic test_back_to_back();
      make_valid();
      grid[80] = 10;
      run_check("b2b_first", 0);
      make_valid();
      run_check("b2b_second", 0);
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'd0;
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 test_reset();
      @(negedge clk) rst = 1'b0;
      test_valid();
      test_row_dup();
      test_range();
      test_box_dup();
      test_early_dup5();
      test_reset_mid_scan();
      test_random();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sudoku_checker.md
Name: sudoku_checker

Overview:
- Downstream of the solver/writer stage: after the grid has been written to RAM, it reads all 81 cells back and validates them.
- Checks each cell holds 1..9, and that no digit repeats in any row, column or 3x3 box.
- Reports pass/fail plus the address and kind of the first failing cell; the top level uses this to qualify the final done.

Parameters:
- ADDR_W, 7, RAM address width.
- DATA_W, 8, RAM data width; the cell value is the full unsigned word.
- BASE_ADDR, 0, RAM address of cell 0; cells are row-major at BASE_ADDR..BASE_ADDR+80.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a check; ignored unless in IDLE or REPORT.
- RAM_ceb  output  1  RAM access enable (1 = access).
- RAM_web  output  1  write enable, active low; tied to 1 (read only).
- RAM_A  output  ADDR_W  RAM read address.
- RAM_Q  input  DATA_W  read data, valid the cycle after RAM_A is presented with RAM_ceb=1.
- busy  output  1  high in SCAN and DRAIN.
- chk_done  output  1  high in REPORT; held until the next start or reset.
- pass  output  1  valid while chk_done is high; 1 = grid valid.
- err_addr  output  7  cell index 0..80 of the first failing cell; 0 when pass.
- err_code  output  2  0 none, 1 value out of range (0 or >9), 2 duplicate.

Behaviour:
- Reset (synchronous, rst=1 at an edge), at any time including mid-scan:
  - state=IDLE; all 27 masks cleared.
  - RAM_ceb=0, RAM_A=0, RAM_web=1.
  - busy=0, chk_done=0, pass=0, err_addr=0, err_code=0.
  - Any in-flight read is discarded.
- FSM states: IDLE, SCAN, DRAIN, REPORT.
  - IDLE --start--> SCAN. REPORT --start--> SCAN.
  - SCAN --issue count==80--> DRAIN. DRAIN --> REPORT.
- Entering SCAN clears the 9 row masks, 9 column masks, 9 box masks (9 bits each), the error latch, and chk_done/pass.
- SCAN:
  - Each cycle k (0..80): RAM_ceb=1, RAM_A=BASE_ADDR+k.
  - Exactly 81 reads, no gaps. RAM_ceb=0 in all other states.
- Check stage, one cycle behind issue:
  - Uses a delayed valid bit and the cell index, row (0..8), column (0..8) and box=(row/3)*3+col/3.
  - Row, column and box are held as counters; no dividers.
- Per checked cell with value v:
  - v==0 or v>9: code 1, masks unchanged.
  - Otherwise, if bit v-1 is already set in its row, column or box mask: code 2.
  - Otherwise set bit v-1 in all three masks.
  - Code 1 takes priority over code 2 for the same cell.
  - A duplicate is flagged at the later (higher-index) occurrence.
- Only the first error is latched into err_addr/err_code; later errors are ignored.
- Latency: start sampled at edge N → SCAN cycles N+1..N+81 → DRAIN N+82 (checks cell 80) → chk_done=1 from N+83.
- In REPORT: pass=1 iff no error latched.
- start while busy=1: ignored, no effect on the running scan.
- start in REPORT: restarts, and chk_done drops the next cycle.
- The upper bits of RAM_Q above the compared range still count toward the ">9" test.

Optional Feature:
- Macro SUDOKU_CHK_EARLY_EXIT_EN.
- Defined:
  - On the first error the FSM goes straight to REPORT on the next edge.
  - No further reads are issued; the one in-flight read is discarded.
  - chk_done rises exactly 1 cycle after the failing cell's check cycle.
- Undefined:
  - A full 81-cell scan always runs; chk_done always rises at N+83.
  - Reported error is still the first one.

Decomposition:
- Shared package sudoku_pkg:
  - constants GRID_DIM=9, N_CELLS=81;
  - err_code encodings ERR_NONE/ERR_RANGE/ERR_DUP;
  - checker state encoding.
- One sub-module, sudoku_pos_tracker: holds the index/row/column/box counters. Clear and advance inputs; wraps column 8→0 with row increment; box derived incrementally.

Test Plan:
- Valid solved grid in RAM, start at cycle N → chk_done=1 at N+83, pass=1, err_code=0, err_addr=0; exactly 81 RAM_ceb cycles, addresses 0..80.
- Solved grid with cell 10 set to the same value as cell 9 (same row) → pass=0, err_code=2, err_addr=10.
- Cell 40 = 0 and cell 60 = 12 → err_code=1, err_addr=40 (first error only).
- Box-only duplicate (cells 0 and 10 equal, with row/column otherwise valid) → err_code=2, err_addr=10.
- rst asserted at scan cycle 30, then start → RAM_ceb low the cycle after reset; next check completes normally with a fresh result; start pulses during busy are ignored.
- Early exit (macro defined), duplicate at cell 5 → the check for cell 5 occurs at N+7 and chk_done=1 at N+8. Macro undefined: chk_done at N+83 with the same err_addr=5.
